// File: rtl/pps_sync_pkg.sv
// Shared constants for the PPS pulse-burst generator: state codes and widths.
package pps_sync_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 4'd0,
        HIGH = 4'd1,
        LOW  = 4'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a registered rising-edge pulse.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic sync1_q;
    logic sync2_q;
    logic sync_d_q;
    logic rise_q;

    // The rise flag is registered so the FSM sees a clean one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync_d_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= i_async;
            sync2_q  <= sync1_q;
            sync_d_q <= sync2_q;
            rise_q   <= sync2_q & ~sync_d_q;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/pps_sync_v2.sv
// PPS-aligned pulse-burst generator: each SYNC rising edge (re)starts a burst of
// PULSE_NUM square pulses, each HALF_PERIOD clocks high then HALF_PERIOD clocks low.
module pps_sync_v2
    import pps_sync_pkg::*;
#(
    parameter int unsigned PULSE_NUM   = 5,
    parameter int unsigned HALF_PERIOD = 100
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                SYNC,
    output logic                pps_trig_out,
    output logic [CNT_W-1:0]    o_pulse_number,
    output logic [CNT_W-1:0]    o_half_period_cnt,
    output logic [STATE_W-1:0]  o_cstate,
    output logic [STATE_W-1:0]  o_nstate
);

    logic               rise;
    logic               phase_done;
    logic [STATE_W-1:0] cstate_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pnum_q, pnum_d;

    sync_edge_detect u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (SYNC),
        .o_rise  (rise)
    );

    assign phase_done = (cnt_q == CNT_W'(HALF_PERIOD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cstate_q <= IDLE;
            cnt_q    <= '0;
            pnum_q   <= '0;
        end else begin
            cstate_q <= state_d;
            cnt_q    <= cnt_d;
            pnum_q   <= pnum_d;
        end
    end

    // A new PPS edge always wins, aborting any burst in progress.
    always_comb begin
        state_d = cstate_q;
        cnt_d   = cnt_q;
        pnum_d  = pnum_q;
        if (rise) begin
            state_d = HIGH;
            cnt_d   = '0;
            pnum_d  = CNT_W'(1);
        end else begin
            case (cstate_q)
                IDLE: state_d = IDLE;
                HIGH: begin
                    if (phase_done) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        if (pnum_q == CNT_W'(PULSE_NUM)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            pnum_d  = '0;
                        end else begin
                            state_d = HIGH;
                            cnt_d   = '0;
                            pnum_d  = pnum_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pnum_d  = '0;
                end
            endcase
        end
    end

    assign pps_trig_out      = (cstate_q == HIGH);
    assign o_pulse_number    = pnum_q;
    assign o_half_period_cnt = cnt_q;
    assign o_cstate          = cstate_q;
    assign o_nstate          = state_d;

endmodule

// File: tb/tb_pps_sync_v2.sv
// Scoreboard bench for pps_sync_v2: a burst-time reference model queues the expected
// outputs each clock, and a negedge monitor pops and compares them.
module tb_pps_sync_v2;

    localparam int unsigned PN    = 5;
    localparam int unsigned HP    = 100;
    localparam int unsigned BURST = 2 * PN * HP;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        sync  = 1'b0;
    logic        pps_trig_out;
    logic [31:0] o_pulse_number;
    logic [31:0] o_half_period_cnt;
    logic [3:0]  o_cstate;
    logic [3:0]  o_nstate;

    always #5 clk = ~clk;

    pps_sync_v2 #(.PULSE_NUM(PN), .HALF_PERIOD(HP)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .SYNC              (sync),
        .pps_trig_out      (pps_trig_out),
        .o_pulse_number    (o_pulse_number),
        .o_half_period_cnt (o_half_period_cnt),
        .o_cstate          (o_cstate),
        .o_nstate          (o_nstate)
    );

    typedef struct {
        bit          trig;
        int unsigned pnum;
        int unsigned cnt;
        int unsigned cst;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected outputs from the time elapsed since the burst started.
    function automatic exp_t expect_of(input bit act, input int unsigned tt);
        exp_t e;
        int unsigned ph;
        e.trig = 1'b0; e.pnum = 0; e.cnt = 0; e.cst = 0;
        if (act) begin
            ph     = tt % (2 * HP);
            e.trig = (ph < HP);
            e.cnt  = ph % HP;
            e.pnum = tt / (2 * HP) + 1;
            e.cst  = e.trig ? 1 : 2;
        end
        return e;
    endfunction

    // Reference model: a SYNC 0->1 seen between two edge samples starts a burst three edges later.
    bit          hist[5];
    bit          active = 1'b0;
    int unsigned t      = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) hist[i] = 1'b0;
            active = 1'b0;
            t      = 0;
        end else begin
            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sync;
            if (hist[3] && !hist[4]) begin
                active = 1'b1;
                t      = 0;
            end else if (active) begin
                t++;
                if (t == BURST) begin
                    active = 1'b0;
                    t      = 0;
                end
            end
        end
        expq.push_back(expect_of(active, t));
    end

    // Monitor: compare every clock; o_nstate is checked against the next cycle's expected state.
    logic [3:0] prev_n = 4'd0;
    bit         nvalid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            if (!rst_n) e = expect_of(1'b0, 0);
            cmp("trig",   longint'(pps_trig_out),      longint'(e.trig));
            cmp("pnum",   longint'(o_pulse_number),    longint'(e.pnum));
            cmp("cnt",    longint'(o_half_period_cnt), longint'(e.cnt));
            cmp("cstate", longint'(o_cstate),          longint'(e.cst));
            if (nvalid && rst_n) cmp("nstate", longint'(prev_n), longint'(e.cst));
            prev_n = o_nstate;
            nvalid = rst_n;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_trig"},   longint'(pps_trig_out),      0);
        cmp({tag, "_pnum"},   longint'(o_pulse_number),    0);
        cmp({tag, "_cnt"},    longint'(o_half_period_cnt), 0);
        cmp({tag, "_cstate"}, longint'(o_cstate),          0);
        cmp({tag, "_nstate"}, longint'(o_nstate),          0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cyc(10);
        check_idle("reset_hold");
        rst_n = 1'b1;
        cyc(20);
        check_idle("idle_after_release");

        // SYNC already high when reset releases
        rst_n = 1'b0;
        sync  = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(100);
        sync = 1'b0;
        cyc(1100);

        // 1000-cycle PPS period, rise lands at the tail of the burst
        for (int p = 0; p < 3; p++) begin
            sync = 1'b1;
            cyc(100);
            sync = 1'b0;
            cyc(900);
        end
        cyc(1100);

        // Second rise during the high phase of pulse 2
        sync = 1'b1;
        cyc(100);
        sync = 1'b0;
        cyc(150);
        sync = 1'b1;
        cyc(50);
        sync = 1'b0;
        cyc(1100);

        // SYNC held high: one burst only
        sync = 1'b1;
        cyc(3000);
        sync = 1'b0;
        cyc(50);

        // Async reset in the middle of pulse 3
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        cyc(453);
        cmp("pre_reset_trig", longint'(pps_trig_out),      1);
        cmp("pre_reset_pnum", longint'(o_pulse_number),    3);
        cmp("pre_reset_cnt",  longint'(o_half_period_cnt), 50);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(500);
        check_idle("idle_after_async_reset");
        sync = 1'b1;
        cyc(10);
        sync = 1'b0;
        cyc(2100);

        // Randomized PPS high/low lengths
        for (int r = 0; r < 12; r++) begin
            sync = 1'b1;
            cyc(int'($urandom_range(1, 300)));
            sync = 1'b0;
            cyc(int'($urandom_range(1, 1500)));
        end
        cyc(2100);
        check_idle("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pps_sync_v2.md
Name: pps_sync_v2

Overview:
- Converts an asynchronous PPS (pulse-per-second) input into a burst of PULSE_NUM square pulses on pps_trig_out.
- Each pulse is HALF_PERIOD clocks high followed by HALF_PERIOD clocks low.
- Every new PPS rising edge re-phases the burst, so downstream FOG/PIG sampling logic stays aligned to GPS time.
- State and counters are exported for debug.

Parameters:
- PULSE_NUM, default 5: number of pulses per burst; must be ≥1.
- HALF_PERIOD, default 100: length of each high phase and each low phase, in i_clk cycles; must be ≥1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- SYNC  input  1  PPS input, asynchronous to i_clk.
- pps_trig_out  output  1  pulse-burst output.
- o_pulse_number  output  32  1-based index of the current pulse within the burst; 0 when idle.
- o_half_period_cnt  output  32  cycle counter within the current phase.
- o_cstate  output  4  current FSM state.
- o_nstate  output  4  combinational next FSM state.

Behaviour:
- Reset (async assert, sync release): all registers cleared, including synchronizer and edge flops. Outputs are pps_trig_out=0, o_pulse_number=0, o_half_period_cnt=0, o_cstate=IDLE, o_nstate=IDLE (SYNC low).
- SYNC path:
  - Two-flop synchronizer, then a delay flop.
  - rise = sync2 & ~sync_d.
  - Exactly one rise pulse per SYNC low→high transition.
  - SYNC held high produces no further rises.
  - SYNC already high at reset release counts as a rise.
- State encoding, 4 bits: IDLE=0, HIGH=1, LOW=2. Codes 3–15 are illegal and map to IDLE on the next clock.
- Transitions, evaluated each clock with rise having priority:
  - Any state with rise → HIGH. Counter cleared to 0; o_pulse_number set to 1. This is a restart: a burst in progress is aborted.
  - IDLE without rise: stays IDLE.
  - HIGH without rise: if cnt == HALF_PERIOD−1 → LOW with cnt cleared; otherwise cnt+1.
  - LOW without rise, cnt == HALF_PERIOD−1:
    - if o_pulse_number == PULSE_NUM → IDLE; cnt and o_pulse_number both cleared to 0;
    - otherwise → HIGH; cnt cleared; o_pulse_number incremented by 1.
  - LOW without rise, cnt below HALF_PERIOD−1: cnt+1.
- pps_trig_out = (cstate == HIGH). It is decoded from the state register only, so it is glitch-free.
- Latency: SYNC is first sampled high at clock edge k; rise is valid after edge k+2; cstate becomes HIGH and pps_trig_out rises at edge k+3.
- Burst timing with no interruption:
  - each high phase and each low phase lasts exactly HALF_PERIOD cycles;
  - total burst = 2·PULSE_NUM·HALF_PERIOD cycles;
  - then IDLE.
- PPS period shorter than the burst: the remaining burst is truncated and a fresh burst starts at the next rise. If this hits during a high phase, pps_trig_out stays high and the counter restarts.
- Counter width: 32 bits. The counter never exceeds HALF_PERIOD−1, so no wrap-around.
- o_nstate is the combinational next-state value that cstate will load on the next edge.

Decomposition:
- Package pps_sync_pkg:
  - state localparams IDLE, HIGH, LOW;
  - state width constant (4).
- Sub-module sync_edge_detect:
  - 2-flop synchronizer plus rising-edge detector;
  - ports i_clk, i_rst_n, async in, rise out.
- FSM, counters and output decode live in pps_sync_v2.

Test Plan (10 ns clock, PULSE_NUM=5, HALF_PERIOD=100):
- Reset held with SYNC=0 → all outputs 0 and o_cstate=0. Release with SYNC=0 → outputs stay idle.
- SYNC rises at reset release, high 100 cycles → pps_trig_out rises 3 clocks after the first high sample. Then five 100-high/100-low pulses, o_pulse_number stepping 1..5, then IDLE with counters 0.
- SYNC period 1000 cycles (100 high, 900 low) for 3 periods → each new rise lands in the 5th low phase about 3 cycles before its end. Required response: restart to HIGH with o_pulse_number=1, o_half_period_cnt=0; no extra or missing pulses.
- Second SYNC rise 250 cycles into a burst (HIGH phase, pulse 2) → burst restarts immediately: pulse_number=1, cnt=0, output stays high.
- SYNC held high for 3000 cycles → exactly one burst of 5 pulses, then IDLE.
- Async reset asserted mid-pulse 3 → all outputs 0 immediately, without waiting for a clock edge. After release with SYNC low → stays IDLE until the next SYNC rise.
